// File: rtl/clk_div_monitor.sv
// Measures period/high time of a clk-synchronous divided clock; flags lock, mismatch, stall.
// Results register on the posedge detecting the closing rise; no backpressure, din is sampled every cycle.
module clk_div_monitor #(
   parameter int CNT_W    = 8,
   parameter int LOCK_CNT = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             din,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             err,
   output logic             stuck
);

   localparam int MC_W = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [MC_W-1:0]  MATCH_TGT = MC_W'(LOCK_CNT);
   localparam logic [MC_W-1:0]  MATCH_PRE = MC_W'(LOCK_CNT - 1);

   typedef enum logic {IDLE, MEAS} state_t;

   state_t           state, state_nxt;
   logic             din_q;
   logic             rise;
   logic             start, meas, stall, same;
   logic [CNT_W-1:0] per_cnt, hi_cnt;
   logic             have_prev;
   logic [MC_W-1:0]  match_cnt;

   assign rise = din & ~din_q;
   assign same = (per_cnt == period) && (hi_cnt == high_time);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         din_q <= 1'b0;
      end else begin
         state <= state_nxt;
         din_q <= din;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rise) state_nxt = MEAS;
         MEAS:    if (!rise && per_cnt == CNT_MAX) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      start = 1'b0;
      meas  = 1'b0;
      stall = 1'b0;
      case (state)
         IDLE: start = rise;
         MEAS: begin
            meas  = rise;
            stall = !rise && (per_cnt == CNT_MAX);
         end
         default: ;
      endcase
   end

   // The rise cycle itself is the first sample of the new interval, hence the reload to 1.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end else if (start || meas) begin
         per_cnt <= CNT_ONE;
         hi_cnt  <= CNT_ONE;
      end else if (state == MEAS && !stall) begin
         per_cnt <= per_cnt + CNT_ONE;
         hi_cnt  <= hi_cnt + CNT_W'(din);
      end else begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         err        <= 1'b0;
         stuck      <= 1'b0;
         have_prev  <= 1'b0;
         match_cnt  <= '0;
      end else begin
         meas_valid <= meas;
         err        <= 1'b0;
         if (start)
            stuck <= 1'b0;
         if (meas) begin
            period    <= per_cnt;
            high_time <= hi_cnt;
            have_prev <= 1'b1;
            // Comparison is against the previous result, still held in period/high_time.
            if (have_prev) begin
               if (same) begin
                  if (match_cnt != MATCH_TGT)
                     match_cnt <= match_cnt + MC_W'(1);
                  if (match_cnt >= MATCH_PRE)
                     locked <= 1'b1;
               end else begin
                  match_cnt <= '0;
                  locked    <= 1'b0;
                  err       <= locked;
               end
            end
         end
         if (stall) begin
            stuck     <= 1'b1;
            have_prev <= 1'b0;
            match_cnt <= '0;
            locked    <= 1'b0;
            err       <= locked;
         end
      end
   end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: div2/div4/div6 lock, duty change, stall, async reset.
// Inputs change 1 time unit after posedge; outputs are sampled at that same point.
module tb_clk_div_monitor;

   localparam int CNT_W    = 8;
   localparam int LOCK_CNT = 2;

   logic             clk    = 1'b0;
   logic             resetn = 1'b0;
   logic             din    = 1'b0;
   logic [CNT_W-1:0] period, high_time;
   logic             meas_valid, locked, err, stuck;

   int vectors     = 0;
   int miscompares = 0;
   int err_cnt     = 0;

   clk_div_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .din        (din),
      .period     (period),
      .high_time  (high_time),
      .meas_valid (meas_valid),
      .locked     (locked),
      .err        (err),
      .stuck      (stuck)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (err === 1'b1) err_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic d);
      din = d;
      @(posedge clk);
      #1;
   endtask

   // Assumes the last step was a rise; plays one interval ending on the next rise.
   task automatic interval(input int per, input int hi);
      for (int i = 1; i < hi; i++) step(1'b1);
      for (int i = 0; i < per - hi; i++) step(1'b0);
      step(1'b1);
   endtask

   task automatic check_meas(input string tag, input int per, input int hi,
                             input logic lk, input logic e);
      check({tag, ".period"},     32'(period),     per);
      check({tag, ".high_time"},  32'(high_time),  hi);
      check({tag, ".meas_valid"}, 32'(meas_valid), 1);
      check({tag, ".locked"},     32'(locked),     32'(lk));
      check({tag, ".err"},        32'(err),        32'(e));
   endtask

   initial begin
      // Reset state
      #12;
      check("rst.period",     32'(period),     0);
      check("rst.high_time",  32'(high_time),  0);
      check("rst.meas_valid", 32'(meas_valid), 0);
      check("rst.locked",     32'(locked),     0);
      check("rst.err",        32'(err),        0);
      check("rst.stuck",      32'(stuck),      0);
      @(negedge clk);
      resetn = 1'b1;

      // div2 from reset
      step(1'b0);
      check("div2.idle_mv", 32'(meas_valid), 0);
      step(1'b1);
      check("div2.rise1_mv", 32'(meas_valid), 0);
      step(1'b0);
      check("div2.mid_mv", 32'(meas_valid), 0);
      step(1'b1);
      check_meas("div2.m1", 2, 1, 1'b0, 1'b0);
      step(1'b0);
      check("div2.mv_pulse", 32'(meas_valid), 0);
      step(1'b1);
      check_meas("div2.m2", 2, 1, 1'b0, 1'b0);
      interval(2, 1);
      check_meas("div2.m3", 2, 1, 1'b1, 1'b0);
      check("div2.err_cnt", err_cnt, 0);

      // Async reset mid-interval while locked, din held high through release
      step(1'b0);
      #3;
      resetn = 1'b0;
      din    = 1'b1;
      #1;
      check("arst.period",     32'(period),     0);
      check("arst.high_time",  32'(high_time),  0);
      check("arst.meas_valid", 32'(meas_valid), 0);
      check("arst.locked",     32'(locked),     0);
      check("arst.err",        32'(err),        0);
      check("arst.stuck",      32'(stuck),      0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      check("arst.rise_mv",     32'(meas_valid), 0);
      check("arst.rise_period", 32'(period),     0);
      step(1'b0);
      step(1'b1);
      check_meas("arst.m1", 2, 1, 1'b0, 1'b0);
      interval(2, 1);
      check_meas("arst.m2", 2, 1, 1'b0, 1'b0);
      interval(2, 1);
      check_meas("arst.m3", 2, 1, 1'b1, 1'b0);

      // div4
      interval(4, 2);
      check_meas("div4.m1", 4, 2, 1'b0, 1'b1);
      interval(4, 2);
      check_meas("div4.m2", 4, 2, 1'b0, 1'b0);
      interval(4, 2);
      check_meas("div4.m3", 4, 2, 1'b1, 1'b0);

      // div6
      interval(6, 3);
      check_meas("div6.m1", 6, 3, 1'b0, 1'b1);
      interval(6, 3);
      check_meas("div6.m2", 6, 3, 1'b0, 1'b0);
      interval(6, 3);
      check_meas("div6.m3", 6, 3, 1'b1, 1'b0);

      // back to div4, then a duty change at constant period
      interval(4, 2);
      check_meas("div4b.m1", 4, 2, 1'b0, 1'b1);
      interval(4, 2);
      interval(4, 2);
      check_meas("div4b.m3", 4, 2, 1'b1, 1'b0);
      interval(4, 1);
      check_meas("duty.m1", 4, 1, 1'b0, 1'b1);
      interval(4, 1);
      check_meas("duty.m2", 4, 1, 1'b0, 1'b0);
      interval(4, 1);
      check_meas("duty.m3", 4, 1, 1'b1, 1'b0);
      check("duty.err_cnt", err_cnt, 4);

      // Stall: din held low after lock
      for (int i = 0; i < 254; i++) step(1'b0);
      check("stall.pre_stuck",  32'(stuck),  0);
      check("stall.pre_locked", 32'(locked), 1);
      step(1'b0);
      check("stall.stuck",      32'(stuck),      1);
      check("stall.err",        32'(err),        1);
      check("stall.locked",     32'(locked),     0);
      check("stall.meas_valid", 32'(meas_valid), 0);
      check("stall.period",     32'(period),     4);
      check("stall.high_time",  32'(high_time),  1);
      step(1'b0);
      check("stall.err_once", 32'(err),   0);
      check("stall.held",     32'(stuck), 1);

      // Restart div2
      step(1'b1);
      check("restart.stuck", 32'(stuck),      0);
      check("restart.mv",    32'(meas_valid), 0);
      step(1'b0);
      step(1'b1);
      check_meas("restart.m1", 2, 1, 1'b0, 1'b0);
      interval(2, 1);
      check_meas("restart.m2", 2, 1, 1'b0, 1'b0);
      interval(2, 1);
      check_meas("restart.m3", 2, 1, 1'b1, 1'b0);
      step(1'b0);
      check("final.err_cnt", err_cnt, 5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Measurement block for divided-clock signals such as the div2/div4/div6 outputs of the even clock divider. It samples a slow, clk-synchronous periodic input and reports its period and high time in clk cycles. It declares lock after a run of identical periods and flags deviations or a stalled input. It sits beside the divider as its checking end, in the same clk domain.

## Interface
- CNT_W, 8: width of period/high-time counters; maximum measurable period is 2^CNT_W-1 cycles.
- LOCK_CNT, 2: consecutive matching comparisons required to assert locked (≥1).

- clk  in  1  sole clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset; clears all state immediately.
- din  in  1  monitored divided clock, synchronous to clk; sampled directly, with no synchronizer.
- period  out  CNT_W  last measured rising-to-rising interval, in clk cycles.
- high_time  out  CNT_W  cycles din was sampled high within that interval.
- meas_valid  out  1  one-cycle pulse when period/high_time are updated.
- locked  out  1  input period and high time stable.
- err  out  1  one-cycle pulse: lock lost due to mismatch or stall.
- stuck  out  1  no rising edge within 2^CNT_W-1 cycles; held until next rising edge.

## Operation
- din_q: registered copy of din, reset 0.
- rise = din & ~din_q, evaluated at each posedge.
- Two states, IDLE and MEAS. Reset state is IDLE.
- IDLE: counters per_cnt and hi_cnt are held at 0. On rise: go to MEAS, per_cnt<=1, hi_cnt<=1, stuck<=0.
- MEAS with no rise: per_cnt<=per_cnt+1; hi_cnt<=hi_cnt+1 when din=1.
- MEAS with rise:
  - period<=per_cnt, high_time<=hi_cnt, meas_valid<=1.
  - per_cnt<=1, hi_cnt<=1.
  - Compare step (below) runs against the old period/high_time.
- Compare step, only when have_prev=1:
  - Both values equal: match_cnt increments, saturating at LOCK_CNT.
  - Either value differs: match_cnt<=0. If locked was 1, err pulses and locked clears.
  - have_prev<=1 after every measurement.
- locked<=1 at the posedge where match_cnt reaches LOCK_CNT.
- Stall: in MEAS, per_cnt=2^CNT_W-1 with no rise causes all of the following at that posedge:
  - stuck<=1, state to IDLE.
  - have_prev<=0, match_cnt<=0.
  - If locked was 1: locked<=0 and err pulses.
  - period and high_time keep their last values.
- Counter rules: unsigned. per_cnt cannot exceed 2^CNT_W-1 because of the stall rule. hi_cnt ≤ per_cnt always.
- Constant-high din: detected as a stall; there is no further rise.

## Timing
- Reset values: period=0, high_time=0, meas_valid=0, locked=0, err=0, stuck=0, din_q=0, state IDLE, have_prev=0, match_cnt=0.
- din high at reset release: the first posedge sees a rise and starts MEAS. This is legal.
- Latency: period for interval [rise k, rise k+1] is visible right after the posedge detecting rise k+1. meas_valid is high for exactly that one cycle.
- First meas_valid comes at the second detected rise.
- With LOCK_CNT=2, locked asserts with the 3rd meas_valid when all three measurements are equal.
- err and meas_valid are coincident on a mismatch. err alone on a stall.
- Reset asserted mid-measurement clears everything asynchronously. There is no report of the partial interval.

## Test plan
- div2 pattern (din 0,1,0,1,…) from reset → first meas_valid 2 cycles after first rise; period=2, high_time=1; locked=1 on 3rd meas_valid; err never pulses.
- div4 (1,1,0,0 repeating) then div6 (1,1,1,0,0,0 repeating) → period=4/high_time=2 then locked. At the first 6-cycle interval: period=6, high_time=3, err pulse, locked=0. Relocks after 2 further 6-cycle periods.
- Duty change at constant period (1,0,0,0 after locked 1,1,0,0) → period=4, high_time=1, err pulse, locked drops.
- din held 0 after lock, CNT_W=8 → 255 cycles after last rise: stuck=1, err pulse, locked=0, period unchanged. Restart div2 → stuck clears on first rise; meas_valid 2 cycles later.
- resetn asserted mid-interval while locked → all outputs 0 immediately (asynchronous). After release, the first measurement requires two rises again.
- din high throughout reset release → rise on first posedge; subsequent div2 toggling gives period=2 normally.
